// File: rtl/intr_controller.sv
// ---------------------------------------------------------------------------
// intr_controller
//
// Four-source, fixed-priority, edge-triggered interrupt controller with a
// single-level (non-nesting) request/acknowledge/return handshake to a CPU.
// IRQ[0] has the highest priority.
//
// Ports
//   CLK         in   system clock, all state changes on the rising edge
//   RST_N       in   synchronous active-low reset
//   IRQ[3:0]    in   interrupt sources, rising-edge sensitive
//   MASK_WE     in   load MASK from MASK_IN on the next edge
//   MASK_IN[3:0] in  new mask value, 1 = source enabled
//   I_EN        in   CPU global interrupt enable
//   INT_ACK     in   CPU accepted the current request (one-cycle pulse)
//   RETI        in   CPU returned from the interrupt handler (one-cycle pulse)
//   INTR        out  registered interrupt request
//   VEC_ID[1:0] out  registered index of the requested / serviced source
//   IN_SERVICE  out  registered, high while a handler is running
//   PENDING[3:0] out registered pending bits
//
// State      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no request outstanding; arbitrate when I_EN and eligible set
// ST_REQ     | INTR high, VEC_ID frozen, waiting for INT_ACK
// ST_SERVICE | handler running, no new requests until RETI
// ---------------------------------------------------------------------------
module intr_controller (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] IRQ,
  input  logic       MASK_WE,
  input  logic [3:0] MASK_IN,
  input  logic       I_EN,
  input  logic       INT_ACK,
  input  logic       RETI,
  output logic       INTR,
  output logic [1:0] VEC_ID,
  output logic       IN_SERVICE,
  output logic [3:0] PENDING
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] irq_q;
  logic [3:0] mask;
  logic [3:0] irq_edge;
  logic [3:0] eligible;
  logic [3:0] pend_clr;
  logic [1:0] winner;
  logic       ack_taken;

  assign irq_edge  = IRQ & ~irq_q;
  assign eligible  = PENDING & mask;
  assign ack_taken = (state == ST_REQ) && INT_ACK;

  // Lowest index wins.
  always_comb begin
    winner = 2'd0;
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
    else if (eligible[3]) winner = 2'd3;
  end

  always_comb begin
    pend_clr = 4'b0000;
    if (ack_taken) pend_clr = 4'b0001 << VEC_ID;
  end

  // Edge detect, mask and pending bits. A new edge on the same cycle as the
  // acknowledge clear re-arms the bit (set has priority over clear).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      irq_q   <= 4'b0000;
      mask    <= 4'b0000;
      PENDING <= 4'b0000;
    end else begin
      irq_q   <= IRQ;
      if (MASK_WE) mask <= MASK_IN;
      PENDING <= (PENDING & ~pend_clr) | irq_edge;
    end
  end

  // Request/acknowledge/return sequencing. Once in ST_REQ the request is
  // sticky: mask or I_EN changes cannot withdraw it, only INT_ACK or reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      INTR       <= 1'b0;
      VEC_ID     <= 2'd0;
      IN_SERVICE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          INTR <= 1'b0;
          if (I_EN && (eligible != 4'b0000)) begin
            VEC_ID <= winner;
            INTR   <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (INT_ACK) begin
            INTR       <= 1'b0;
            IN_SERVICE <= 1'b1;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (RETI) begin
            IN_SERVICE <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          INTR       <= 1'b0;
          IN_SERVICE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
module tb_intr_controller;

  logic       CLK;
  logic       RST_N;
  logic [3:0] IRQ;
  logic       MASK_WE;
  logic [3:0] MASK_IN;
  logic       I_EN;
  logic       INT_ACK;
  logic       RETI;
  logic       INTR;
  logic [1:0] VEC_ID;
  logic       IN_SERVICE;
  logic [3:0] PENDING;

  intr_controller dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IRQ        (IRQ),
    .MASK_WE    (MASK_WE),
    .MASK_IN    (MASK_IN),
    .I_EN       (I_EN),
    .INT_ACK    (INT_ACK),
    .RETI       (RETI),
    .INTR       (INTR),
    .VEC_ID     (VEC_ID),
    .IN_SERVICE (IN_SERVICE),
    .PENDING    (PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One vector = inputs for one edge plus the expected outputs after it,
  // packed as {INTR, VEC_ID[1:0], IN_SERVICE, PENDING[3:0]}.
  typedef struct {
    logic       rst_n;
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] min;
    logic       i_en;
    logic       ack;
    logic       reti;
    logic [7:0] exp;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] e(input logic intr, input logic [1:0] vec,
                                   input logic insvc, input logic [3:0] pend);
    return {intr, vec, insvc, pend};
  endfunction

  function automatic vec_t v(input logic rst_n, input logic [3:0] irq,
                             input logic mwe, input logic [3:0] min,
                             input logic i_en, input logic ack,
                             input logic reti, input logic [7:0] exp);
    vec_t r;
    r.rst_n = rst_n; r.irq = irq; r.mwe = mwe; r.min = min;
    r.i_en = i_en; r.ack = ack; r.reti = reti; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    RST_N   = t.rst_n;
    IRQ     = t.irq;
    MASK_WE = t.mwe;
    MASK_IN = t.min;
    I_EN    = t.i_en;
    INT_ACK = t.ack;
    RETI    = t.reti;
    exp_q.push_back(t.exp);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(0, 4'hF, 1, 4'hF, 1, 1, 1, e(0, 0, 0, 4'h0)));
    t.push_back(v(0, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_reset step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  // Single source, plus INT_ACK outside REQ / RETI outside SERVICE ignored.
  task automatic test_basic();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'h0, 1, 4'hF, 1, 0, 0, e(0, 0, 0, 4'h0)));
    t.push_back(v(1, 4'h4, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 2, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 2, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 2, 0, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 1, e(0, 2, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_basic step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  task automatic test_priority();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'hA, 0, 4'h0, 1, 0, 0, e(0, 2, 0, 4'hA)));
    t.push_back(v(1, 4'hA, 0, 4'h0, 1, 0, 0, e(1, 1, 0, 4'hA)));
    t.push_back(v(1, 4'hA, 0, 4'h0, 1, 1, 0, e(0, 1, 1, 4'h8)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 1, 0, 4'h8)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 3, 0, 4'h8)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 3, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 3, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_priority step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  task automatic test_mask();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'h0, 1, 4'hE, 1, 0, 0, e(0, 3, 0, 4'h0)));
    t.push_back(v(1, 4'h1, 0, 4'h0, 1, 0, 0, e(0, 3, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 3, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 3, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 1, 4'hF, 1, 0, 0, e(0, 3, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 0, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 1, 4'h0, 1, 0, 0, e(1, 0, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 0, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 1, 4'hF, 1, 0, 1, e(0, 0, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_mask step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  task automatic test_ien();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'h4, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 0, 1, 0, e(0, 2, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 2, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_ien step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  // Re-edge while pending is absorbed; re-edge on the ack edge re-arms.
  task automatic test_collision();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'h4, 0, 4'h0, 1, 0, 0, e(0, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h4, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h4, 0, 4'h0, 1, 1, 0, e(0, 2, 1, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 2, 1, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 2, 0, 4'h4)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 2, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 2, 0, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(0, 2, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_collision step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  // Reset during SERVICE with PENDING=1010; IRQ[3] held high through reset.
  task automatic test_reset_abort();
    vec_t       t[$];
    logic [7:0] x;
    t.push_back(v(1, 4'h1, 0, 4'h0, 1, 0, 0, e(0, 2, 0, 4'h1)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 0, e(1, 0, 0, 4'h1)));
    t.push_back(v(1, 4'hA, 0, 4'h0, 1, 1, 0, e(0, 0, 1, 4'hA)));
    t.push_back(v(0, 4'h8, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h0)));
    t.push_back(v(1, 4'h8, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h8)));
    t.push_back(v(1, 4'h8, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h8)));
    t.push_back(v(1, 4'h8, 0, 4'h0, 1, 0, 0, e(0, 0, 0, 4'h8)));
    t.push_back(v(1, 4'h8, 1, 4'hF, 1, 0, 0, e(0, 0, 0, 4'h8)));
    t.push_back(v(1, 4'h8, 0, 4'h0, 1, 0, 0, e(1, 3, 0, 4'h8)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, e(0, 3, 1, 4'h0)));
    t.push_back(v(1, 4'h0, 0, 4'h0, 1, 0, 1, e(0, 3, 0, 4'h0)));
    foreach (t[i]) begin
      drive(t[i]);
      x = exp_q.pop_front();
      vectors++;
      if ({INTR, VEC_ID, IN_SERVICE, PENDING} !== x) begin
        miscompares++;
        $display("FAIL test_reset_abort step %0d: got %b required %b", i,
                 {INTR, VEC_ID, IN_SERVICE, PENDING}, x);
      end
    end
  endtask

  initial begin
    RST_N   = 1'b0;
    IRQ     = 4'h0;
    MASK_WE = 1'b0;
    MASK_IN = 4'h0;
    I_EN    = 1'b0;
    INT_ACK = 1'b0;
    RETI    = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_ien();
    test_collision();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
